// File: rtl/hack_cpu.sv
// Multi-cycle Hack CPU core: FETCH waits on the ROM handshake, DECODE covers the
// RAM read latency, EXECUTE runs the ALU and commits A/D/PC/memory on one edge.
module hack_cpu #(
    parameter logic [15:0] PC_RESET = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [15:0] pc,
    output logic        fetch_req,
    input  logic [15:0] instruction,
    input  logic        instr_valid,
    output logic [15:0] address_m,
    input  logic [15:0] in_m,
    output logic [15:0] out_m,
    output logic        write_m
);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_DECODE  = 2'd1,
        ST_EXECUTE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_a;
    logic [15:0] r_d;
    logic [15:0] r_pc;
    logic [15:0] r_ir;
    logic        r_fetch_req;
    logic        r_write_m;

    logic [15:0] w_y;
    logic [15:0] w_alu;
    logic        w_jump;
    logic [15:0] w_pc_inc;
    logic [15:0] w_a_nxt;
    logic [15:0] w_d_nxt;
    logic [15:0] w_pc_nxt;
    logic [15:0] w_ir_nxt;
    logic        w_write_nxt;

    // Hack ALU; c = {zx, nx, zy, ny, f, no}.
    function automatic logic [15:0] hack_alu(input logic [15:0] x_in,
                                             input logic [15:0] y_in,
                                             input logic [5:0]  c);
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] o;
        x = c[5] ? 16'h0000 : x_in;
        x = c[4] ? ~x : x;
        y = c[3] ? 16'h0000 : y_in;
        y = c[2] ? ~y : y;
        o = c[1] ? (x + y) : (x & y);
        o = c[0] ? ~o : o;
        return o;
    endfunction

    // Jump condition from ALU flags; j = {lt, eq, gt}.
    function automatic logic jump_taken(input logic [15:0] o, input logic [2:0] j);
        logic zr;
        logic ng;
        zr = (o == 16'h0000);
        ng = o[15];
        return (j[2] & ng) | (j[1] & zr) | (j[0] & ~ng & ~zr);
    endfunction

    // ALU operands, result and branch decision for the instruction held in IR.
    always_comb begin
        w_y      = r_ir[12] ? in_m : r_a;
        w_alu    = hack_alu(r_d, w_y, r_ir[11:6]);
        w_jump   = r_ir[15] & jump_taken(w_alu, r_ir[2:0]);
        w_pc_inc = r_pc + 16'd1;
    end

    // Next-state logic of the fetch/decode/execute sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FETCH: begin
                if (instr_valid) begin
                    w_state_nxt = ST_DECODE;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_DECODE:  w_state_nxt = ST_EXECUTE;
            ST_EXECUTE: w_state_nxt = ST_FETCH;
            default:    w_state_nxt = ST_FETCH;
        endcase
    end

    // Architectural register updates; all EXECUTE destinations see pre-EXECUTE values.
    always_comb begin
        w_a_nxt     = r_a;
        w_d_nxt     = r_d;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_write_nxt = 1'b0;
        if ((r_state == ST_FETCH) && instr_valid) begin
            w_ir_nxt = instruction;
        end else begin
            w_ir_nxt = r_ir;
        end
        if (r_state == ST_EXECUTE) begin
            w_pc_nxt = w_jump ? r_a : w_pc_inc;
            if (!r_ir[15]) begin
                w_a_nxt = {1'b0, r_ir[14:0]};
            end else begin
                w_a_nxt = r_ir[5] ? w_alu : r_a;
                w_d_nxt = r_ir[4] ? w_alu : r_d;
            end
        end else begin
            w_pc_nxt = r_pc;
        end
        // IR already holds the instruction while in DECODE, so the strobe can be registered.
        if (w_state_nxt == ST_EXECUTE) begin
            w_write_nxt = r_ir[15] & r_ir[3];
        end else begin
            w_write_nxt = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers and registered handshake/strobe outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a         <= 16'h0000;
            r_d         <= 16'h0000;
            r_pc        <= PC_RESET;
            r_ir        <= 16'h0000;
            r_fetch_req <= 1'b0;
            r_write_m   <= 1'b0;
        end else begin
            r_a         <= w_a_nxt;
            r_d         <= w_d_nxt;
            r_pc        <= w_pc_nxt;
            r_ir        <= w_ir_nxt;
            r_fetch_req <= (w_state_nxt == ST_FETCH);
            r_write_m   <= w_write_nxt;
        end
    end

    assign pc        = r_pc;
    assign fetch_req = r_fetch_req;
    assign address_m = r_a;
    assign write_m   = r_write_m;
    assign out_m     = (r_state == ST_EXECUTE) ? w_alu : 16'h0000;

endmodule

// File: tb/tb_hack_cpu.sv
// Self-checking bench for hack_cpu: directed scenarios plus randomized programs
// compared against an instruction-level Hack model with its own data memory.
module tb_hack_cpu;

    localparam logic [15:0] PC_RST = 16'h0000;
    localparam logic [5:0] COMP_TAB [18] = '{
        6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
        6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
        6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101};

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] pc;
    logic        fetch_req;
    logic [15:0] instruction;
    logic        instr_valid;
    logic [15:0] address_m;
    logic [15:0] in_m;
    logic [15:0] out_m;
    logic        write_m;

    int n_checks = 0;
    int n_pass   = 0;

    hack_cpu #(.PC_RESET(PC_RST)) dut (
        .clk(clk), .reset_n(reset_n), .pc(pc), .fetch_req(fetch_req),
        .instruction(instruction), .instr_valid(instr_valid),
        .address_m(address_m), .in_m(in_m), .out_m(out_m), .write_m(write_m));

    always #5 clk = ~clk;

    function automatic logic [15:0] ram_init(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hA5C3;
    endfunction

    // Synchronous-read data RAM seen by the DUT.
    bit [15:0] ram    [65536];
    bit        ram_wr [65536];
    always @(posedge clk) begin
        if (write_m) begin
            ram[address_m]    <= out_m;
            ram_wr[address_m] <= 1'b1;
        end
        in_m <= ram_wr[address_m] ? ram[address_m] : ram_init(address_m);
    end

    // Reference model state.
    logic [15:0] m_a, m_d, m_pc;
    bit   [15:0] m_mem  [65536];
    bit          m_memw [65536];
    logic [15:0] exp_out, exp_addr, exp_pc, exp_a;
    logic        exp_wr;

    // Observations from the last do_instr.
    logic [15:0] obs_ex_out, obs_ex_addr, obs_ex_pc, obs_post_pc, obs_post_addr;
    logic        obs_ex_wr, obs_dec_fr, obs_post_fr, obs_post_wr;
    int          obs_fr_low, obs_pc_move, obs_wr_out;

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        return m_memw[a] ? m_mem[a] : ram_init(a);
    endfunction

    // Mnemonic-level meaning of the 18 standard Hack computations (y is A or M).
    function automatic logic [15:0] hack_comp(input logic [5:0] c, input logic [15:0] x,
                                              input logic [15:0] y);
        case (c)
            6'b101010: return 16'd0;
            6'b111111: return 16'd1;
            6'b111010: return 16'hFFFF;
            6'b001100: return x;
            6'b110000: return y;
            6'b001101: return ~x;
            6'b110001: return ~y;
            6'b001111: return 16'd0 - x;
            6'b110011: return 16'd0 - y;
            6'b011111: return x + 16'd1;
            6'b110111: return y + 16'd1;
            6'b001110: return x - 16'd1;
            6'b110010: return y - 16'd1;
            6'b000010: return x + y;
            6'b010011: return x - y;
            6'b000111: return y - x;
            6'b000000: return x & y;
            6'b010101: return x | y;
            default:   return 16'hxxxx;
        endcase
    endfunction

    task automatic model_reset();
        m_a = 16'h0000; m_d = 16'h0000; m_pc = PC_RST;
    endtask

    task automatic model_exec(input logic [15:0] ins);
        logic [15:0] y, res;
        logic        taken;
        exp_addr = m_a; exp_wr = 1'b0; exp_out = 16'h0000;
        if (ins[15] == 1'b0) begin
            m_a  = {1'b0, ins[14:0]};
            m_pc = m_pc + 16'd1;
        end else begin
            y   = ins[12] ? mem_rd(m_a) : m_a;
            res = hack_comp(ins[11:6], m_d, y);
            exp_out = res;
            exp_wr  = ins[3];
            if (ins[3]) begin m_mem[m_a] = res; m_memw[m_a] = 1'b1; end
            taken = (ins[2] && $signed(res) < 0) || (ins[1] && res == 16'h0000) ||
                    (ins[0] && $signed(res) > 0);
            m_pc = taken ? m_a : m_pc + 16'd1;
            if (ins[5]) m_a = res;
            if (ins[4]) m_d = res;
        end
        exp_pc = m_pc; exp_a = m_a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction through fetch (with stall cycles), decode and execute.
    task automatic do_instr(input logic [15:0] ins, input int stall, input bit noise);
        logic [15:0] pc0;
        pc0 = m_pc;
        obs_fr_low = 0; obs_pc_move = 0; obs_wr_out = 0;
        for (int s = 0; s < stall; s++) begin
            instr_valid = 1'b0; instruction = 16'($urandom);
            tick();
            if (fetch_req !== 1'b1) obs_fr_low++;
            if (pc !== pc0) obs_pc_move++;
            if (write_m !== 1'b0) obs_wr_out++;
        end
        model_exec(ins);
        instruction = ins; instr_valid = 1'b1;
        tick();
        obs_dec_fr = fetch_req;
        if (write_m !== 1'b0) obs_wr_out++;
        if (pc !== pc0) obs_pc_move++;
        instr_valid = noise ? 1'($urandom) : 1'b1;
        instruction = noise ? 16'($urandom) : ins;
        tick();
        obs_ex_out = out_m; obs_ex_wr = write_m; obs_ex_addr = address_m; obs_ex_pc = pc;
        if (pc !== pc0) obs_pc_move++;
        tick();
        obs_post_pc = pc; obs_post_addr = address_m; obs_post_fr = fetch_req;
        obs_post_wr = write_m;
        instr_valid = 1'b0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0; instr_valid = 1'b1; instruction = 16'($urandom);
        tick(); tick();
        #2;
        reset_n = 1'b1;
        instr_valid = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; instr_valid = 1'b1; instruction = 16'h0005;
        tick(); tick();
        n_checks++; if (pc !== PC_RST) $display("FAIL rst_pc: got %h want %h", pc, PC_RST); else n_pass++;
        n_checks++; if (fetch_req !== 1'b0) $display("FAIL rst_fetch_req: got %b want 0", fetch_req); else n_pass++;
        n_checks++; if (write_m !== 1'b0) $display("FAIL rst_write_m: got %b want 0", write_m); else n_pass++;
        n_checks++; if (out_m !== 16'h0000) $display("FAIL rst_out_m: got %h want 0000", out_m); else n_pass++;
        n_checks++; if (address_m !== 16'h0000) $display("FAIL rst_address_m: got %h want 0000", address_m); else n_pass++;
        #2;
        reset_n = 1'b1;
        model_reset();
        do_instr(16'h0005, 0, 1'b0);
        n_checks++; if (obs_ex_pc !== 16'd0) $display("FAIL prog_pc0: got %h want 0000", obs_ex_pc); else n_pass++;
        n_checks++; if (obs_dec_fr !== 1'b0) $display("FAIL prog_dec_fetch_req: got %b want 0", obs_dec_fr); else n_pass++;
        n_checks++; if (obs_post_pc !== 16'd1) $display("FAIL prog_pc1: got %h want 0001", obs_post_pc); else n_pass++;
        n_checks++; if (obs_post_addr !== 16'd5) $display("FAIL prog_a5: got %h want 0005", obs_post_addr); else n_pass++;
        n_checks++; if (obs_post_fr !== 1'b1) $display("FAIL prog_refetch: got %b want 1", obs_post_fr); else n_pass++;
        do_instr(16'hEC10, 0, 1'b0);
        n_checks++; if (obs_post_pc !== 16'd2) $display("FAIL prog_pc2: got %h want 0002", obs_post_pc); else n_pass++;
        n_checks++; if (obs_ex_out !== 16'd5) $display("FAIL prog_d_eq_a: got %h want 0005", obs_ex_out); else n_pass++;
        n_checks++; if ((obs_ex_wr | obs_post_wr) !== 1'b0 || obs_wr_out != 0) $display("FAIL prog_no_write: got %b want 0", obs_ex_wr); else n_pass++;
        do_instr(16'hE300, 0, 1'b0);
        n_checks++; if (obs_ex_out !== 16'd5) $display("FAIL prog_d5: got %h want 0005", obs_ex_out); else n_pass++;
    endtask

    task automatic test_fetch_stall();
        apply_reset();
        do_instr(16'h0064, 7, 1'b0);
        n_checks++; if (obs_fr_low != 0) $display("FAIL stall_fetch_req: got %0d low cycles want 0", obs_fr_low); else n_pass++;
        n_checks++; if (obs_pc_move != 0) $display("FAIL stall_pc_hold: got %0d moves want 0", obs_pc_move); else n_pass++;
        n_checks++; if (obs_dec_fr !== 1'b0) $display("FAIL stall_decode: got fetch_req %b want 0", obs_dec_fr); else n_pass++;
        n_checks++; if (obs_post_addr !== 16'd100) $display("FAIL stall_a: got %h want 0064", obs_post_addr); else n_pass++;
    endtask

    task automatic test_mem_write();
        do_instr(16'h0007, 0, 1'b0);
        do_instr(16'hEC10, 0, 1'b0);
        do_instr(16'h00C8, 0, 1'b0);
        do_instr(16'hE308, 1, 1'b0);
        n_checks++; if (obs_ex_wr !== 1'b1) $display("FAIL mw_strobe: got %b want 1", obs_ex_wr); else n_pass++;
        n_checks++; if (obs_ex_addr !== 16'd200) $display("FAIL mw_addr: got %h want 00c8", obs_ex_addr); else n_pass++;
        n_checks++; if (obs_ex_out !== 16'd7) $display("FAIL mw_data: got %h want 0007", obs_ex_out); else n_pass++;
        n_checks++; if (obs_wr_out != 0 || obs_post_wr !== 1'b0) $display("FAIL mw_one_cycle: got %0d/%b want 0/0", obs_wr_out, obs_post_wr); else n_pass++;
    endtask

    task automatic test_mem_read();
        do_instr(16'hFC10, 0, 1'b0);
        do_instr(16'hE300, 0, 1'b0);
        n_checks++; if (obs_ex_out !== 16'd7) $display("FAIL mr_first: got %h want 0007", obs_ex_out); else n_pass++;
        do_instr(16'h0009, 0, 1'b0);
        do_instr(16'hEC10, 0, 1'b0);
        do_instr(16'h00C8, 0, 1'b0);
        do_instr(16'hE308, 0, 1'b0);
        do_instr(16'hEA90, 0, 1'b0);
        do_instr(16'hFC10, 2, 1'b0);
        do_instr(16'hE300, 0, 1'b0);
        n_checks++; if (obs_ex_out !== 16'd9) $display("FAIL mr_d_eq_m: got %h want 0009", obs_ex_out); else n_pass++;
    endtask

    task automatic test_jumps();
        do_instr(16'hEA90, 0, 1'b0);
        do_instr(16'h002A, 0, 1'b0);
        do_instr(16'hE302, 0, 1'b0);
        n_checks++; if (obs_post_pc !== 16'd42) $display("FAIL jeq_taken: got %h want 002a", obs_post_pc); else n_pass++;
        do_instr(16'hEE90, 0, 1'b0);
        do_instr(16'hE301, 0, 1'b0);
        n_checks++; if (obs_post_pc !== 16'd44) $display("FAIL jgt_not_taken: got %h want 002c", obs_post_pc); else n_pass++;
        do_instr(16'hEEA0, 0, 1'b0);
        n_checks++; if (obs_post_addr !== 16'hFFFF) $display("FAIL a_minus1: got %h want ffff", obs_post_addr); else n_pass++;
        do_instr(16'hEA87, 0, 1'b0);
        n_checks++; if (obs_post_pc !== 16'hFFFF) $display("FAIL jmp_ffff: got %h want ffff", obs_post_pc); else n_pass++;
        do_instr(16'h7FFF, 0, 1'b0);
        n_checks++; if (obs_post_pc !== 16'h0000) $display("FAIL pc_wrap: got %h want 0000", obs_post_pc); else n_pass++;
        n_checks++; if (obs_post_addr !== 16'h7FFF) $display("FAIL a_instr_max: got %h want 7fff", obs_post_addr); else n_pass++;
        do_instr(16'h0004, 0, 1'b0);
        do_instr(16'hEC10, 0, 1'b0);
        do_instr(16'h012C, 0, 1'b0);
        do_instr(16'hE7EF, 0, 1'b0);
        n_checks++; if (obs_ex_wr !== 1'b1 || obs_ex_addr !== 16'd300) $display("FAIL am_jmp_write: got %b@%h want 1@012c", obs_ex_wr, obs_ex_addr); else n_pass++;
        n_checks++; if (obs_ex_out !== 16'd5) $display("FAIL am_jmp_data: got %h want 0005", obs_ex_out); else n_pass++;
        n_checks++; if (obs_post_pc !== 16'd300) $display("FAIL am_jmp_target: got %h want 012c", obs_post_pc); else n_pass++;
        n_checks++; if (obs_post_addr !== 16'd5) $display("FAIL am_jmp_a: got %h want 0005", obs_post_addr); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int wr_seen;
        do_instr(16'h0003, 0, 1'b0);
        do_instr(16'hEC10, 0, 1'b0);
        do_instr(16'h00C8, 0, 1'b0);
        instruction = 16'hE308; instr_valid = 1'b1;
        tick();
        n_checks++; if (fetch_req !== 1'b0) $display("FAIL mid_in_decode: got fetch_req %b want 0", fetch_req); else n_pass++;
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++; if (pc !== PC_RST || address_m !== 16'h0000) $display("FAIL mid_async_clear: got pc %h a %h want %h 0000", pc, address_m, PC_RST); else n_pass++;
        n_checks++; if (out_m !== 16'h0000 || fetch_req !== 1'b0) $display("FAIL mid_outputs: got out %h fr %b want 0000 0", out_m, fetch_req); else n_pass++;
        wr_seen = 0;
        for (int i = 0; i < 3; i++) begin
            if (write_m !== 1'b0) wr_seen++;
            tick();
            if (write_m !== 1'b0) wr_seen++;
        end
        n_checks++; if (wr_seen != 0) $display("FAIL mid_no_write: got %0d strobes want 0", wr_seen); else n_pass++;
        #2;
        reset_n = 1'b1; instr_valid = 1'b0;
        model_reset();
        tick();
        n_checks++; if (fetch_req !== 1'b1 || pc !== PC_RST) $display("FAIL mid_refetch: got fr %b pc %h want 1 %h", fetch_req, pc, PC_RST); else n_pass++;
        do_instr(16'h0011, 0, 1'b0);
        n_checks++; if (obs_post_addr !== 16'h0011 || obs_post_pc !== 16'd1) $display("FAIL mid_restart: got a %h pc %h want 0011 0001", obs_post_addr, obs_post_pc); else n_pass++;
        do_instr(16'h00C8, 0, 1'b0);
        do_instr(16'hFC10, 0, 1'b0);
        do_instr(16'hE300, 0, 1'b0);
        n_checks++; if (obs_ex_out !== 16'd9) $display("FAIL mid_ram_kept: got %h want 0009", obs_ex_out); else n_pass++;
    endtask

    task automatic test_random();
        logic [15:0] ins;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                ins = {1'b0, 15'($urandom)};
            end else begin
                ins = {1'b1, 2'($urandom), 1'($urandom), COMP_TAB[$urandom_range(0, 17)],
                       3'($urandom), 3'($urandom)};
            end
            do_instr(ins, int'($urandom_range(0, 2)), 1'b1);
            n_checks++; if (obs_post_pc !== exp_pc) $display("FAIL rnd_pc[%0d] ins %h: got %h want %h", k, ins, obs_post_pc, exp_pc); else n_pass++;
            n_checks++; if (obs_post_addr !== exp_a) $display("FAIL rnd_a[%0d] ins %h: got %h want %h", k, ins, obs_post_addr, exp_a); else n_pass++;
            n_checks++; if (obs_ex_wr !== exp_wr) $display("FAIL rnd_write[%0d] ins %h: got %b want %b", k, ins, obs_ex_wr, exp_wr); else n_pass++;
            n_checks++; if (obs_ex_addr !== exp_addr) $display("FAIL rnd_addr[%0d] ins %h: got %h want %h", k, ins, obs_ex_addr, exp_addr); else n_pass++;
            if (ins[15]) begin
                n_checks++; if (obs_ex_out !== exp_out) $display("FAIL rnd_out[%0d] ins %h: got %h want %h", k, ins, obs_ex_out, exp_out); else n_pass++;
            end
            n_checks++; if (obs_fr_low != 0 || obs_pc_move != 0 || obs_wr_out != 0 || obs_dec_fr !== 1'b0) $display("FAIL rnd_handshake[%0d]: got %0d/%0d/%0d/%b want 0/0/0/0", k, obs_fr_low, obs_pc_move, obs_wr_out, obs_dec_fr); else n_pass++;
        end
    endtask

    initial begin
        instruction = 16'h0000;
        instr_valid = 1'b0;
        reset_n     = 1'b0;
        model_reset();
        test_reset();
        test_fetch_stall();
        test_mem_write();
        test_mem_read();
        test_jumps();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
